// File: rtl/wifi_tx_interleaver_pkg.sv
// Shared WIFI TX constants: modulation encodings and per-modulation symbol geometry.
// The interleaver and the mapper both use these definitions.
package wifi_tx_interleaver_pkg;

    localparam int MAX_NCBPS = 288;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_e;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_e;

    // step = NCBPS/16, s = max(NBPSC/2, 1)
    typedef struct packed {
        logic [ADDR_W-1:0] ncbps;
        logic [4:0]        step;
        logic [1:0]        s;
    } mod_cfg_t;

    function automatic logic [ADDR_W-1:0] ncbps_of(input mod_e m);
        logic [ADDR_W-1:0] n;
        case (m)
            MOD_BPSK:  n = 9'd48;
            MOD_QPSK:  n = 9'd96;
            MOD_16QAM: n = 9'd192;
            default:   n = 9'd288;
        endcase
        return n;
    endfunction

    function automatic mod_cfg_t mod_cfg(input mod_e m);
        mod_cfg_t c;
        c.ncbps = ncbps_of(m);
        case (m)
            MOD_BPSK:  begin c.step = 5'd3;  c.s = 2'd1; end
            MOD_QPSK:  begin c.step = 5'd6;  c.s = 2'd1; end
            MOD_16QAM: begin c.step = 5'd12; c.s = 2'd2; end
            default:   begin c.step = 5'd18; c.s = 2'd3; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wifi_tx_interleaver_addr_gen.sv
// Incremental k -> j address generator for the two-permutation 802.11a interleaver.
// Tracks the write count, the first-permutation index i and two small mod-s counters.
module wifi_tx_interleaver_addr_gen
    import wifi_tx_interleaver_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  mod_cfg_t          cfg,
    output logic [ADDR_W-1:0] wr_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [3:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] i_idx;
    logic [1:0]        r_mod;
    logic [1:0]        c_mod;
    logic [1:0]        rot;

    assign last = (wr_cnt == cfg.ncbps - ADDR_W'(1));

    // floor(16*i/NCBPS) equals col and NCBPS is a multiple of s, so the
    // rotation term reduces to (i - col) mod s built from the two counters.
    // NOTE: rot gets its value on every path before any condition, so no latch is inferred.
    always_comb begin
        rot = r_mod - c_mod;
        if (r_mod < c_mod) begin
            rot = r_mod + cfg.s - c_mod;
        end
    end

    assign addr = i_idx - ADDR_W'(r_mod) + ADDR_W'(rot);

    // step is a multiple of s, so i mod s only changes when the row advances.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_cnt <= '0;
            col    <= '0;
            row    <= '0;
            i_idx  <= '0;
            r_mod  <= '0;
            c_mod  <= '0;
        end else if (advance) begin
            if (last) begin
                wr_cnt <= '0;
                col    <= '0;
                row    <= '0;
                i_idx  <= '0;
                r_mod  <= '0;
                c_mod  <= '0;
            end else if (col == 4'd15) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
                col    <= '0;
                row    <= row + 5'd1;
                i_idx  <= ADDR_W'(row) + ADDR_W'(1);
                r_mod  <= (r_mod + 2'd1 == cfg.s) ? 2'd0 : r_mod + 2'd1;
                c_mod  <= '0;
            end else begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
                col    <= col + 4'd1;
                i_idx  <= i_idx + ADDR_W'(cfg.step);
                c_mod  <= (c_mod + 2'd1 == cfg.s) ? 2'd0 : c_mod + 2'd1;
            end
        end
    end

endmodule

// File: rtl/wifi_tx_interleaver.sv
// WIFI TX bit interleaver: ping-pong 288-bit banks written in permuted order,
// read out sequentially by a two-state read FSM.
module wifi_tx_interleaver
    import wifi_tx_interleaver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       data_in,
    input  logic [1:0] mod,
    output logic       valid_out,
    output logic       data_out
);

    logic [MAX_NCBPS-1:0] bank_mem [2];
    mod_e                 bank_mod [2];
    mod_e                 wr_mod_q;
    mod_e                 wr_mod_sel;
    mod_cfg_t             wr_cfg;

    logic                 wr_bank;
    logic                 wr_first;
    logic                 wr_last;
    logic [ADDR_W-1:0]    wr_cnt;
    logic [ADDR_W-1:0]    wr_addr;
    logic [1:0]           full;

    rd_state_e            rd_state, rd_state_nxt;
    logic                 rd_bank, rd_bank_nxt;
    logic [ADDR_W-1:0]    rd_cnt, rd_cnt_nxt;
    logic [ADDR_W-1:0]    rd_addr;
    logic [ADDR_W-1:0]    rd_last_idx;
    logic                 emit;
    logic                 rd_done;

    // The first bit of a symbol uses mod directly; the rest use the latched copy.
    assign wr_first    = (wr_cnt == '0);
    assign wr_mod_sel  = wr_first ? mod_e'(mod) : wr_mod_q;
    assign wr_cfg      = mod_cfg(wr_mod_sel);
    assign rd_last_idx = ncbps_of(bank_mod[rd_bank]) - ADDR_W'(1);

    wifi_tx_interleaver_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .advance (valid_in),
        .cfg     (wr_cfg),
        .wr_cnt  (wr_cnt),
        .addr    (wr_addr),
        .last    (wr_last)
    );

    always_comb begin
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        rd_cnt_nxt   = rd_cnt;
        rd_addr      = rd_cnt;
        emit         = 1'b0;
        rd_done      = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    emit         = 1'b1;
                    rd_addr      = '0;
                    rd_cnt_nxt   = ADDR_W'(1);
                    rd_state_nxt = RD_READ;
                end
            end
            RD_READ: begin
                emit = 1'b1;
                if (rd_cnt == rd_last_idx) begin
                    rd_done      = 1'b1;
                    rd_bank_nxt  = ~rd_bank;
                    rd_cnt_nxt   = '0;
                    rd_state_nxt = full[~rd_bank] ? RD_READ : RD_IDLE;
                end else begin
                    rd_cnt_nxt = rd_cnt + ADDR_W'(1);
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank     <= 1'b0;
            wr_mod_q    <= MOD_BPSK;
            bank_mod[0] <= MOD_BPSK;
            bank_mod[1] <= MOD_BPSK;
            full        <= '0;
            rd_state    <= RD_IDLE;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            valid_out   <= 1'b0;
            data_out    <= 1'b0;
        end else begin
            if (valid_in && wr_first) begin
                wr_mod_q          <= mod_e'(mod);
                bank_mod[wr_bank] <= mod_e'(mod);
            end
            if (valid_in && wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
            if (valid_in && wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            rd_state  <= rd_state_nxt;
            rd_bank   <= rd_bank_nxt;
            rd_cnt    <= rd_cnt_nxt;
            valid_out <= emit;
            data_out  <= emit & bank_mem[rd_bank][rd_addr];
        end
    end

    // NOTE: bank storage has no reset; the full flags gate every read, so stale bits never reach data_out.
    always_ff @(posedge clk) begin
        if (reset && valid_in) begin
            bank_mem[wr_bank][wr_addr] <= data_in;
        end
    end

endmodule
